mtl_lcd_timing_gen: RTL and testbench
=====================================

// Module: mtl_lcd_timing_gen
// PURPOSE
//  Source side of the MTL LCD pixel interface: produces DCLK-domain HSD/VSD/DE and 24b RGB
//  for an 800x480 panel in a 1056x525 frame. Pulls pixels from the upstream pixel source
//  (scaler/line buffer) through a fixed-latency request/data port. Sits between the
//  video buffer and the MTL_* pins of nes_player; the bench pixel capturer is its sink.
// PARAMETERS
//  H_TOTAL      1056  clocks per line (counter 0..H_TOTAL-1)
//  V_TOTAL      525   lines per frame (0..V_TOTAL-1)
//  H_ACT_START  50    first active x; active x = H_ACT_START..H_ACT_START+H_ACT-1
//  H_ACT        800   active pixels per line
//  V_ACT_START  23    first active line
//  V_ACT        480   active lines
//  HSYNC_W      30    HSD low width (clocks), starting at x=0
//  VSYNC_W      13    VSD low width (lines), starting at y=0
//  RD_LAT       2     pixel source read latency, cycles; legal 1..H_ACT_START-1
//  BLANK_RGB    24'h0 colour driven on underrun
// PORTS
//  i_clk_lcd     in   1   LCD pixel clock (drives MTL_DCLK)
//  i_rstn_lcd    in   1   synchronous active-low reset
//  o_pix_req     out  1   pixel read request (combinational from counter)
//  o_pix_x       out  10  requested pixel column 0..H_ACT-1
//  o_pix_y       out  9   requested pixel line 0..V_ACT-1
//  i_pix_vld     in   1   i_pix_rgb valid, RD_LAT cycles after o_pix_req
//  i_pix_rgb     in   24  {R,G,B} 8b each
//  o_hsd         out  1   horizontal sync, active low
//  o_vsd         out  1   vertical sync, active low
//  o_de          out  1   data enable, high in active area
//  o_r/o_g/o_b   out  8   pixel colour
//  o_frame_start out  1   1-cycle pulse, counter at (0,0)
//  o_underrun    out  1   sticky: requested pixel missing in current frame
// BEHAVIOUR
//  - Counters hcnt(11b)/vcnt(10b): hcnt wraps H_TOTAL-1->0; vcnt++ on that wrap, wraps
//    V_TOTAL-1->0 simultaneously with hcnt. No other stall or skip.
//  - All o_hsd/o_vsd/o_de/o_r/g/b/o_frame_start registered: reflect counter of previous cycle.
//  - o_hsd=0 iff hcnt<HSYNC_W; o_vsd=0 iff vcnt<VSYNC_W (whole lines, not H-aligned offset).
//  - o_de=1 iff hcnt in active x AND vcnt in active y.
//  - Request: o_pix_req=1 when vcnt active and hcnt-RD_LAT+... i.e. hcnt in
//    [H_ACT_START-RD_LAT, H_ACT_START+H_ACT-1-RD_LAT]; o_pix_x=hcnt+RD_LAT-H_ACT_START,
//    o_pix_y=vcnt-V_ACT_START. x/y hold 0 when req=0. Exactly H_ACT reqs per active line.
//  - Data: valid-tag shift register of depth RD_LAT tracks outstanding reqs. Data for pixel
//    (px,py) sampled when hcnt=H_ACT_START+px; shown on o_rgb with o_de=1 next cycle.
//  - If tag set and i_pix_vld=0: o_rgb=BLANK_RGB, o_underrun<=1. i_pix_vld with no tag: ignored.
//  - o_rgb=0 whenever o_de=0.
//  - o_underrun cleared on the cycle o_frame_start asserts (set in same cycle wins).
//  - Reset (anytime, incl. mid-line): hcnt=vcnt=0, tags flushed, o_hsd=1, o_vsd=1, o_de=0,
//    rgb=0, o_frame_start=0, o_underrun=0, o_pix_req=0. First cycle after reset release:
//    counter at (0,0), o_frame_start=1 the following cycle.
//  - Data returned after reset for pre-reset reqs is discarded (tags flushed).
// STRUCTURE
//  - Package nes_lcd_pkg: MTL timing defaults (1056/525/50/800/23/480), rgb24_t struct
//    {r,g,b}, widths LCD_HCNT_W=11, LCD_VCNT_W=10.
//  - Sub-module lcd_sync_counter: hcnt/vcnt, wrap, sync/active decode for a given offset;
//    instanced once for the display position. Request window decoded in top.
// TESTING
//  - Reset 10 clks, run 2 frames: HSD period 1056, low 30; VSD period 554400 clks, low 13 lines.
//  - Source returns (x^y) colour with RD_LAT=2: every DE pixel (x,y) equals (x^y), 800x480/frame.
//  - RD_LAT=1 and RD_LAT=49 params: same pixel check passes, 800 reqs/line, 0 outside window.
//  - Drop i_pix_vld for pixel (100,10): that pixel =BLANK_RGB, o_underrun=1 until next frame start.
//  - Assert reset at hcnt=400,vcnt=200: outputs to reset values next clk; release -> frame_start.
//  - Spurious i_pix_vld during blanking: o_rgb stays 0, o_underrun stays 0.

Source files
------------

// File: rtl/mtl_lcd_timing_gen_pkg.sv
// Shared definitions for the MTL LCD timing generator.
// Holds the default 800x480-in-1056x525 panel timing, counter and pixel
// address widths, and the packed colour type used on the pixel path.
package mtl_lcd_timing_gen_pkg;

    localparam int LCD_HCNT_W = 11;
    localparam int LCD_VCNT_W = 10;
    localparam int PIX_X_W    = 10;
    localparam int PIX_Y_W    = 9;

    localparam int MTL_H_TOTAL     = 1056;
    localparam int MTL_V_TOTAL     = 525;
    localparam int MTL_H_ACT_START = 50;
    localparam int MTL_H_ACT       = 800;
    localparam int MTL_V_ACT_START = 23;
    localparam int MTL_V_ACT       = 480;
    localparam int MTL_HSYNC_W     = 30;
    localparam int MTL_VSYNC_W     = 13;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

endpackage

// File: rtl/mtl_lcd_timing_gen_if.sv
// Pixel-source request/data port plus the MTL panel-side outputs.
//   master : timing generator (drives o_*, receives i_pix_*)
//   slave  : pixel source / panel sink (receives o_*, drives i_pix_*)
interface mtl_lcd_timing_gen_if;
    import mtl_lcd_timing_gen_pkg::*;

    logic               o_pix_req;
    logic [PIX_X_W-1:0] o_pix_x;
    logic [PIX_Y_W-1:0] o_pix_y;
    logic               i_pix_vld;
    logic [23:0]        i_pix_rgb;
    logic               o_hsd;
    logic               o_vsd;
    logic               o_de;
    logic [7:0]         o_r;
    logic [7:0]         o_g;
    logic [7:0]         o_b;
    logic               o_frame_start;
    logic               o_underrun;

    modport master (
        output o_pix_req, o_pix_x, o_pix_y,
        input  i_pix_vld, i_pix_rgb,
        output o_hsd, o_vsd, o_de, o_r, o_g, o_b, o_frame_start, o_underrun
    );

    modport slave (
        input  o_pix_req, o_pix_x, o_pix_y,
        output i_pix_vld, i_pix_rgb,
        input  o_hsd, o_vsd, o_de, o_r, o_g, o_b, o_frame_start, o_underrun
    );

endinterface

// File: rtl/mtl_lcd_timing_gen_sync_counter.sv
// Free-running raster counter with sync/active decode.
// Ports: i_clk, i_rstn (sync, active low); o_hcnt/o_vcnt current position;
// o_hsync_n/o_vsync_n sync levels; o_v_act active line; o_act active pixel;
// o_origin position is (0,0).
module mtl_lcd_timing_gen_sync_counter
    import mtl_lcd_timing_gen_pkg::*;
#(
    parameter int H_TOTAL     = MTL_H_TOTAL,
    parameter int V_TOTAL     = MTL_V_TOTAL,
    parameter int H_ACT_START = MTL_H_ACT_START,
    parameter int H_ACT       = MTL_H_ACT,
    parameter int V_ACT_START = MTL_V_ACT_START,
    parameter int V_ACT       = MTL_V_ACT,
    parameter int HSYNC_W     = MTL_HSYNC_W,
    parameter int VSYNC_W     = MTL_VSYNC_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    output logic [LCD_HCNT_W-1:0] o_hcnt,
    output logic [LCD_VCNT_W-1:0] o_vcnt,
    output logic                  o_hsync_n,
    output logic                  o_vsync_n,
    output logic                  o_v_act,
    output logic                  o_act,
    output logic                  o_origin
);

    localparam logic [LCD_HCNT_W-1:0] H_LAST = LCD_HCNT_W'(H_TOTAL - 1);
    localparam logic [LCD_VCNT_W-1:0] V_LAST = LCD_VCNT_W'(V_TOTAL - 1);
    localparam logic [LCD_HCNT_W-1:0] H_AS   = LCD_HCNT_W'(H_ACT_START);
    localparam logic [LCD_HCNT_W-1:0] H_AE   = LCD_HCNT_W'(H_ACT_START + H_ACT);
    localparam logic [LCD_VCNT_W-1:0] V_AS   = LCD_VCNT_W'(V_ACT_START);
    localparam logic [LCD_VCNT_W-1:0] V_AE   = LCD_VCNT_W'(V_ACT_START + V_ACT);
    localparam logic [LCD_HCNT_W-1:0] H_SW   = LCD_HCNT_W'(HSYNC_W);
    localparam logic [LCD_VCNT_W-1:0] V_SW   = LCD_VCNT_W'(VSYNC_W);

    logic [LCD_HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [LCD_VCNT_W-1:0] vcnt_q, vcnt_d;

    // vcnt advances only on the hcnt wrap, so both wrap together at frame end
    always_comb begin
        hcnt_d = hcnt_q + LCD_HCNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + LCD_VCNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign o_hcnt    = hcnt_q;
    assign o_vcnt    = vcnt_q;
    assign o_hsync_n = (hcnt_q >= H_SW);
    assign o_vsync_n = (vcnt_q >= V_SW);
    assign o_v_act   = (vcnt_q >= V_AS) && (vcnt_q < V_AE);
    assign o_act     = o_v_act && (hcnt_q >= H_AS) && (hcnt_q < H_AE);
    assign o_origin  = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/mtl_lcd_timing_gen.sv
// MTL LCD timing generator: raster timing, pixel prefetch and panel outputs.
// Ports: i_clk_lcd pixel clock; i_rstn_lcd sync active-low reset;
// bus (master) carries the pixel request/data port and HSD/VSD/DE/RGB,
// frame-start pulse and sticky underrun flag. All panel outputs are
// registered and reflect the raster position of the previous cycle.
module mtl_lcd_timing_gen
    import mtl_lcd_timing_gen_pkg::*;
#(
    parameter int          H_TOTAL     = MTL_H_TOTAL,
    parameter int          V_TOTAL     = MTL_V_TOTAL,
    parameter int          H_ACT_START = MTL_H_ACT_START,
    parameter int          H_ACT       = MTL_H_ACT,
    parameter int          V_ACT_START = MTL_V_ACT_START,
    parameter int          V_ACT       = MTL_V_ACT,
    parameter int          HSYNC_W     = MTL_HSYNC_W,
    parameter int          VSYNC_W     = MTL_VSYNC_W,
    parameter int          RD_LAT      = 2,
    parameter logic [23:0] BLANK_RGB   = 24'h0
) (
    input  logic                 i_clk_lcd,
    input  logic                 i_rstn_lcd,
    mtl_lcd_timing_gen_if.master bus
);

    // Requests lead the display position by RD_LAT so data lands exactly
    // on the cycle its pixel is decoded as active.
    localparam logic [LCD_HCNT_W-1:0] REQ_LO = LCD_HCNT_W'(H_ACT_START - RD_LAT);
    localparam logic [LCD_HCNT_W-1:0] REQ_HI = LCD_HCNT_W'(H_ACT_START + H_ACT - 1 - RD_LAT);
    localparam logic [LCD_VCNT_W-1:0] V_OFS  = LCD_VCNT_W'(V_ACT_START);

    logic [LCD_HCNT_W-1:0] hcnt;
    logic [LCD_VCNT_W-1:0] vcnt;
    logic                  hsync_n, vsync_n, v_act, act, origin;

    mtl_lcd_timing_gen_sync_counter #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_ACT_START(H_ACT_START), .H_ACT(H_ACT),
        .V_ACT_START(V_ACT_START), .V_ACT(V_ACT),
        .HSYNC_W(HSYNC_W), .VSYNC_W(VSYNC_W)
    ) u_cnt (
        .i_clk     (i_clk_lcd),
        .i_rstn    (i_rstn_lcd),
        .o_hcnt    (hcnt),
        .o_vcnt    (vcnt),
        .o_hsync_n (hsync_n),
        .o_vsync_n (vsync_n),
        .o_v_act   (v_act),
        .o_act     (act),
        .o_origin  (origin)
    );

    logic              pix_req;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic              tag_out, miss;
    rgb24_t            rgb_q, rgb_d;
    logic              hsd_q, hsd_d, vsd_q, vsd_d, de_q, de_d;
    logic              fs_q, fs_d, und_q, und_d;

    assign pix_req     = v_act && (hcnt >= REQ_LO) && (hcnt <= REQ_HI);
    assign bus.o_pix_req = pix_req;
    assign bus.o_pix_x   = pix_req ? PIX_X_W'(hcnt - REQ_LO) : '0;
    assign bus.o_pix_y   = pix_req ? PIX_Y_W'(vcnt - V_OFS) : '0;

    // tag_q[RD_LAT-1] marks the cycle a requested pixel is due back;
    // data arriving without a tag is ignored.
    assign tag_out = tag_q[RD_LAT-1];
    assign miss    = tag_out && !bus.i_pix_vld;

    always_comb begin
        tag_d = RD_LAT'({tag_q, pix_req});
        rgb_d = '0;
        if (act && tag_out)
            rgb_d = bus.i_pix_vld ? rgb24_t'(bus.i_pix_rgb) : rgb24_t'(BLANK_RGB);
        hsd_d = hsync_n;
        vsd_d = vsync_n;
        de_d  = act;
        fs_d  = origin;
        // clears as o_frame_start rises; a miss on that same edge still sets it
        und_d = (und_q && !origin) || miss;
    end

    always_ff @(posedge i_clk_lcd) begin
        if (!i_rstn_lcd) begin
            tag_q <= '0;
            rgb_q <= '0;
            hsd_q <= 1'b1;
            vsd_q <= 1'b1;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            und_q <= 1'b0;
        end else begin
            tag_q <= tag_d;
            rgb_q <= rgb_d;
            hsd_q <= hsd_d;
            vsd_q <= vsd_d;
            de_q  <= de_d;
            fs_q  <= fs_d;
            und_q <= und_d;
        end
    end

    assign bus.o_hsd         = hsd_q;
    assign bus.o_vsd         = vsd_q;
    assign bus.o_de          = de_q;
    assign bus.o_r           = rgb_q.r;
    assign bus.o_g           = rgb_q.g;
    assign bus.o_b           = rgb_q.b;
    assign bus.o_frame_start = fs_q;
    assign bus.o_underrun    = und_q;

endmodule

// File: tb/tb_mtl_lcd_timing_gen.sv
// Bench for mtl_lcd_timing_gen on a reduced raster (64x20 frame) with three
// instances at read latencies 1, 2 and H_ACT_START-1. A queue-based pixel
// source answers every request after the instance's latency; the expected
// panel outputs come from the raster position computed arithmetically from
// the cycle count since reset.
module tb_mtl_lcd_timing_gen;

    localparam int HT    = 64;
    localparam int VT    = 20;
    localparam int HAS   = 12;
    localparam int HA    = 40;
    localparam int VAS   = 4;
    localparam int VA    = 12;
    localparam int HSW   = 6;
    localparam int VSW   = 2;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BLANK = 24'h5A5A5A;

    typedef struct {
        int due;
        int x;
        int y;
    } rq_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int unsigned seed = 0;
    int          drop_x = 0;
    int          drop_y = 0;
    bit          drop_en = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(string tag, int lat, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL lat%0d %s observed=%0h expected=%0h", lat, tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] col(int x, int y);
        return {8'(x ^ y), 8'(x ^ int'(seed)), 8'(y + int'(seed))};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : HAS - 1;

        mtl_lcd_timing_gen_if bus ();

        mtl_lcd_timing_gen #(
            .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT(HA),
            .V_ACT_START(VAS), .V_ACT(VA), .HSYNC_W(HSW), .VSYNC_W(VSW),
            .RD_LAT(LAT), .BLANK_RGB(BLANK)
        ) dut (
            .i_clk_lcd  (clk),
            .i_rstn_lcd (rstn),
            .bus        (bus.master)
        );

        rq_t         q[$];
        int          cyc = 0;
        int          pos = 0;
        bit          pos_ok = 1'b0;
        bit          exp_ok = 1'b0;
        logic        e_hsd, e_vsd, e_de, e_fs, e_und;
        logic [23:0] e_rgb;
        bit          und_m = 1'b0;
        int          de_cnt = 0;
        bit          full = 1'b0;

        always @(negedge clk) begin
            int   h, v;
            bit   vact, act, reqe, sent_ok;
            rq_t  e;

            // panel outputs of this cycle against the previous cycle's model
            if (exp_ok) begin
                chk("hsd", LAT, bus.o_hsd, e_hsd);
                chk("vsd", LAT, bus.o_vsd, e_vsd);
                chk("de", LAT, bus.o_de, e_de);
                chk("rgb", LAT, {bus.o_r, bus.o_g, bus.o_b}, e_rgb);
                chk("frame_start", LAT, bus.o_frame_start, e_fs);
                chk("underrun", LAT, bus.o_underrun, e_und);
                if (bus.o_frame_start) begin
                    if (full) chk("de_per_frame", LAT, de_cnt, HA * VA);
                    de_cnt = 0;
                    full = 1'b1;
                end
                if (bus.o_de) de_cnt++;
            end

            h    = pos % HT;
            v    = pos / HT;
            vact = (v >= VAS) && (v < VAS + VA);
            act  = vact && (h >= HAS) && (h < HAS + HA);
            reqe = vact && (h >= HAS - LAT) && (h <= HAS + HA - 1 - LAT);
            if (pos_ok) begin
                chk("pix_req", LAT, bus.o_pix_req, reqe);
                chk("pix_x", LAT, bus.o_pix_x, reqe ? h + LAT - HAS : 0);
                chk("pix_y", LAT, bus.o_pix_y, reqe ? v - VAS : 0);
            end

            // pixel source: answer the request due now, else maybe a stray beat
            sent_ok = 1'b0;
            bus.i_pix_vld = 1'b0;
            bus.i_pix_rgb = 24'($urandom);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (!(drop_en && e.x == drop_x && e.y == drop_y)) begin
                    bus.i_pix_vld = 1'b1;
                    bus.i_pix_rgb = col(e.x, e.y);
                    sent_ok = 1'b1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.i_pix_vld = 1'b1;
            end
            if (bus.o_pix_req === 1'b1) begin
                e.due = cyc + LAT;
                e.x   = int'(bus.o_pix_x);
                e.y   = int'(bus.o_pix_y);
                q.push_back(e);
            end

            // expectation for the next cycle
            if (!rstn) begin
                e_hsd = 1'b1; e_vsd = 1'b1; e_de = 1'b0; e_rgb = '0;
                e_fs = 1'b0; e_und = 1'b0; und_m = 1'b0;
                pos = 0; pos_ok = 1'b1; exp_ok = 1'b1; full = 1'b0;
            end else if (pos_ok) begin
                e_hsd = (h >= HSW);
                e_vsd = (v >= VSW);
                e_de  = act;
                e_fs  = (pos == 0);
                e_rgb = act ? (sent_ok ? col(h - HAS, v - VAS) : BLANK) : 24'h0;
                und_m = (und_m && pos != 0) || (act && !sent_ok);
                e_und = und_m;
                pos   = (pos + 1) % FRAME;
            end
            cyc++;
        end
    end

    initial begin
        int tgt;
        bit hit;
        seed   = $urandom;
        drop_x = $urandom_range(0, HA - 1);
        drop_y = $urandom_range(0, VA - 1);
        rstn   = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstn = 1'b1;

        // two clean frames, then two with one pixel withheld per frame
        repeat (2 * FRAME) @(posedge clk);
        #1 drop_en = 1'b1;
        repeat (2 * FRAME) @(posedge clk);
        #1 drop_en = 1'b0;

        // reset landing inside the active area, mid-line
        tgt = (VAS + $urandom_range(0, VA - 1)) * HT + HAS + $urandom_range(0, HA - 1);
        hit = 1'b0;
        for (int i = 0; i < FRAME + 5 && !hit; i++) begin
            @(posedge clk);
            if (gen_dut[0].pos == tgt) hit = 1'b1;
        end
        chk("reset_target_reached", 2, hit, 1'b1);
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (FRAME + 100) @(posedge clk);

        // single-cycle reset at a random point
        repeat ($urandom_range(1, FRAME)) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (FRAME + 100) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
